// File: rtl/div_seq.sv
// div_seq: iterative unsigned restoring divider, one quotient bit per clock
module div_seq #(
    parameter int NW = 8,
    parameter int DW = 4,
    localparam int CW = $clog2(NW + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] numerator,
    input  logic [DW-1:0] denominator,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state, state_n;
    logic [NW-1:0] n, n_n, n_it, q_n;
    logic [DW:0]   d, d_n, r, r_n, rs, r_it;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] rem_n;
    logic          z_n, ge, accept;

    assign busy = state == RUN;
    assign done = state == FIN;

    // next state, one restoring step, and result capture on entry to FIN
    always_comb begin
        state_n = state;
        n_n     = n;
        d_n     = d;
        r_n     = r;
        cnt_n   = cnt;
        q_n     = quotient;
        rem_n   = remainder;
        z_n     = div_by_zero;
        rs      = (r << 1) | (DW + 1)'(n[NW-1]);
        ge      = rs >= d;
        r_it    = ge ? rs - d : rs;
        n_it    = {n[NW-2:0], ge};
        accept  = start && state != RUN;
        if (accept) begin
            n_n   = numerator;
            d_n   = {1'b0, denominator};
            r_n   = '0;
            cnt_n = CW'(NW);
            z_n   = 1'b0;
            if (denominator == '0) begin
                state_n = FIN;
                q_n     = '1;
                rem_n   = '0;
                z_n     = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (state == RUN) begin
            n_n   = n_it;
            r_n   = r_it;
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_n = FIN;
                q_n     = n_it;
                rem_n   = r_it[DW-1:0];
            end
        end else if (state == FIN) begin
            state_n = IDLE;
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            n           <= '0;
            d           <= '0;
            r           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            n           <= n_n;
            d           <= d_n;
            r           <= r_n;
            cnt         <= cnt_n;
            quotient    <= q_n;
            remainder   <= rem_n;
            div_by_zero <= z_n;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and sweep checks of div_seq at 8/4 and 16/8 widths
module tb_div_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  num8 = '0;
    logic [3:0]  den8 = '0;
    logic [15:0] num16 = '0;
    logic [7:0]  den16 = '0;
    logic        busy8, done8, z8, busy16, done16, z16;
    logic [7:0]  q8;
    logic [3:0]  r8;
    logic [15:0] q16;
    logic [7:0]  r16;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    div_seq #(.NW(8), .DW(4)) u8 (
        .clk(clk), .reset(reset), .start(start8), .numerator(num8), .denominator(den8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    div_seq #(.NW(16), .DW(8)) u16 (
        .clk(clk), .reset(reset), .start(start16), .numerator(num16), .denominator(den16),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
    );

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drives one start pulse and returns the result seen in the done cycle
    task automatic issue(input bit w, input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] rm, output logic z,
                         output int lat, output int bc);
        if (w) begin
            num16 = a; den16 = b; start16 = 1'b1;
        end else begin
            num8 = a[7:0]; den8 = b[3:0]; start8 = 1'b1;
        end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        lat = 1; bc = 0;
        while (!(w ? done16 : done8) && lat < 64) begin
            bc += int'(w ? busy16 : busy8);
            @(posedge clk); #1;
            lat++;
        end
        q  = w ? q16 : {8'd0, q8};
        rm = w ? r16 : {4'd0, r8};
        z  = w ? z16 : z8;
    endtask

    initial begin
        vec_t        v[12];
        logic [15:0] q;
        logic [7:0]  rm;
        logic        z;
        int          lat, bc;
        bit          seen;
        v[0]  = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
        v[1]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
        v[2]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
        v[3]  = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
        v[4]  = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0};
        v[5]  = '{8'd123, 4'd0,  8'd255, 4'd0, 1'b1};
        v[6]  = '{8'd10,  4'd3,  8'd3,   4'd1, 1'b0};
        v[7]  = '{8'd100, 4'd10, 8'd10,  4'd0, 1'b0};
        v[8]  = '{8'd0,   4'd0,  8'd255, 4'd0, 1'b1};
        v[9]  = '{8'd1,   4'd15, 8'd0,   4'd1, 1'b0};
        v[10] = '{8'd254, 4'd2,  8'd127, 4'd0, 1'b0};
        v[11] = '{8'd14,  4'd14, 8'd1,   4'd0, 1'b0};

        #12;
        chk("reset_outs8", {busy8, done8, q8, r8, z8}, '0);
        chk("reset_outs16", {busy16, done16, q16, r16, z16}, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // vectors issued back-to-back: each start lands in the previous FIN cycle
        for (int i = 0; i < 12; i++) begin
            issue(1'b0, {8'd0, v[i].a}, {4'd0, v[i].b}, q, rm, z, lat, bc);
            chk($sformatf("vec%0d_q", i), q, {8'd0, v[i].q});
            chk($sformatf("vec%0d_r", i), rm, {4'd0, v[i].r});
            chk($sformatf("vec%0d_z", i), z, v[i].z);
            chk($sformatf("vec%0d_lat", i), lat, v[i].b == 0 ? 1 : 9);
            chk($sformatf("vec%0d_busy", i), bc, v[i].b == 0 ? 0 : 8);
        end

        // results hold after the done pulse
        @(posedge clk); #1;
        chk("hold", {done8, q8, r8, z8}, {1'b0, 8'd1, 4'd0, 1'b0});

        // start during RUN is ignored
        num8 = 8'd200; den8 = 4'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        num8 = 8'd50; den8 = 4'd5; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; num8 = 8'd0; den8 = 4'd0;
        lat = 4;
        while (!done8 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_lat", lat, 9);
        chk("ignore_res", {q8, r8, z8}, {8'd28, 4'd4, 1'b0});

        // reset mid-RUN aborts immediately with no done
        @(posedge clk); #1;
        num8 = 8'd200; den8 = 4'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_outs", {busy8, done8, q8, r8, z8}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            seen |= done8;
        end
        chk("abort_no_done", seen, 1'b0);
        issue(1'b0, 16'd100, 8'd10, q, rm, z, lat, bc);
        chk("after_abort", {q, rm, z, 8'(lat)}, {16'd10, 8'd0, 1'b0, 8'd9});

        // exhaustive 8/4 sweep against the arithmetic reference
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(1'b0, 16'(a), 8'(b), q, rm, z, lat, bc);
                chk($sformatf("sweep8 %0d/%0d", a, b), {q, rm, z, 8'(lat)},
                    b == 0 ? {16'd255, 8'd0, 1'b1, 8'd1}
                           : {16'(a / b), 8'(a % b), 1'b0, 8'd9});
            end
        end

        // random 16/8 pairs, including a few zero denominators
        for (int i = 0; i < 300; i++) begin
            int a, b;
            a = int'($urandom_range(0, 65535));
            b = (i % 25 == 0) ? 0 : int'($urandom_range(0, 255));
            issue(1'b1, 16'(a), 8'(b), q, rm, z, lat, bc);
            chk($sformatf("rand16 %0d/%0d", a, b), {q, rm, z, 8'(lat)},
                b == 0 ? {16'hffff, 8'd0, 1'b1, 8'd1}
                       : {16'(a / b), 8'(a % b), 1'b0, 8'd17});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
